// File: rtl/mux_4x1_rr_pkg.sv
// Shared constants, FSM state type and index helper for the 4:1 round-robin merge.
// Packet lock build option: MUX_4X1_RR_PKT_LOCK_EN.
package mux_4x1_rr_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Channel index offset from a base, wrapping 3 -> 0 through the 2-bit width.
    function automatic logic [SEL_W-1:0] rr_offset(input logic [SEL_W-1:0] base,
                                                   input logic [SEL_W-1:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/mux_4x1_rr_arbiter.sv
// Combinational 4-way round-robin arbiter: search starts one past last_grant,
// returns a one-hot grant and its encoded index (all zero when nothing requests).
module rr_arbiter_4
    import mux_4x1_rr_pkg::*;
(
    input  logic [NCH-1:0]   req_i,
    input  logic [SEL_W-1:0] last_grant_i,
    output logic [NCH-1:0]   grant_o,
    output logic [SEL_W-1:0] grant_idx_o
);

    logic             found_s;
    logic [SEL_W-1:0] cand_s;

    // Offsets 1..4 give the priority order; offset 4 truncates to last_grant itself.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found_s     = 1'b0;
        cand_s      = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand_s = rr_offset(last_grant_i, SEL_W'(i));
            if (!found_s && req_i[cand_s]) begin
                found_s         = 1'b1;
                grant_o[cand_s] = 1'b1;
                grant_idx_o     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mux_4x1_rr.sv
// 4:1 valid/ready merge with round-robin arbitration and a single output register.
// Optional packet lock (in_last/out_last ports, LOCKED state): MUX_4X1_RR_PKT_LOCK_EN.
module mux_4x1_rr
    import mux_4x1_rr_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      in_valid,
    input  logic [NCH*DW-1:0]   in_data,
`ifdef MUX_4X1_RR_PKT_LOCK_EN
    input  logic [NCH-1:0]      in_last,
`endif
    output logic [NCH-1:0]      in_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [SEL_W-1:0]    out_sel,
`ifdef MUX_4X1_RR_PKT_LOCK_EN
    output logic                out_last,
`endif
    input  logic                out_ready
);

    logic                out_valid_q;
    logic [DW-1:0]       out_data_q;
    logic [SEL_W-1:0]    out_sel_q;
    logic [SEL_W-1:0]    last_grant_q;
    logic                load_en_s;
    logic                xfer_s;
    logic [NCH-1:0]      req_s;
    logic [NCH-1:0]      grant_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic [DW-1:0]       sel_data_s;
`ifdef MUX_4X1_RR_PKT_LOCK_EN
    state_e              state_q;
    logic [SEL_W-1:0]    lock_ch_q;
    logic                out_last_q;
`endif

    // While a packet is open only its owning channel may compete.
    always_comb begin
        req_s = in_valid;
`ifdef MUX_4X1_RR_PKT_LOCK_EN
        if (state_q == LOCKED) begin
            req_s = in_valid & (NCH'(1) << lock_ch_q);
        end else begin
            req_s = in_valid;
        end
`endif
    end

    rr_arbiter_4 u_arb (
        .req_i        (req_s),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_s),
        .grant_idx_o  (grant_idx_s)
    );

    assign load_en_s  = !out_valid_q || out_ready;
    // rst_n gating keeps in_ready low for the whole reset window, not just after the first edge.
    assign in_ready   = grant_s & {NCH{load_en_s & rst_n}};
    assign xfer_s     = |in_ready;
    assign sel_data_s = in_data[int'(grant_idx_s)*DW +: DW];

    // Output register, last_grant and packet-lock state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sel_q    <= '0;
            last_grant_q <= SEL_W'(NCH - 1);
`ifdef MUX_4X1_RR_PKT_LOCK_EN
            state_q      <= ARB;
            lock_ch_q    <= '0;
            out_last_q   <= 1'b0;
`endif
        end else if (xfer_s) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= sel_data_s;
            out_sel_q    <= grant_idx_s;
            last_grant_q <= grant_idx_s;
`ifdef MUX_4X1_RR_PKT_LOCK_EN
            out_last_q   <= in_last[grant_idx_s];
            if (in_last[grant_idx_s]) begin
                state_q <= ARB;
            end else begin
                state_q   <= LOCKED;
                lock_ch_q <= grant_idx_s;
            end
`endif
        end else if (load_en_s) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
`ifdef MUX_4X1_RR_PKT_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_mux_4x1_rr.sv
// Scoreboard bench for mux_4x1_rr: directed vectors push expected beats, a negedge
// monitor pops and compares; a random phase checks per-channel order and counts.
module tb_mux_4x1_rr;

    localparam int DW = 8;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
`ifdef MUX_4X1_RR_PKT_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
`endif

    int          checks   = 0;
    int          failures = 0;
    beat_t       exp_q[$];
    bit          rnd_mode = 1'b0;
    logic [5:0]  tx_seq[4];
    logic [5:0]  rx_seq[4];
    int          tx_cnt[4];
    int          rx_cnt[4];
    logic        stall_prev = 1'b0;
    logic [7:0]  data_prev  = 8'h00;
    logic [1:0]  sel_prev   = 2'd0;

    always #5 clk = ~clk;

    mux_4x1_rr #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef MUX_4X1_RR_PKT_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
`ifdef MUX_4X1_RR_PKT_LOCK_EN
        .out_last  (out_last),
`endif
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] sel, input logic [7:0] data, input logic last);
        beat_t b;
        b.sel  = sel;
        b.data = data;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ready_is(input string name, input logic [3:0] exp);
        #1;
        chk(name, 32'(in_ready), 32'(exp));
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks stall stability.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            chk("in_ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(data_prev));
                chk("stall_sel", 32'(out_sel), 32'(sel_prev));
            end
            if (out_valid && out_ready) begin
                if (rnd_mode) begin
                    chk("rnd_chan", 32'(out_data[7:6]), 32'(out_sel));
                    chk("rnd_seq", 32'(out_data[5:0]), 32'(rx_seq[out_sel]));
                    rx_seq[out_sel] = rx_seq[out_sel] + 6'd1;
                    rx_cnt[out_sel]++;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual sel=%0d data=%0h expected none", out_sel, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_sel", 32'(out_sel), 32'(e.sel));
                    chk("beat_data", 32'(out_data), 32'(e.data));
`ifdef MUX_4X1_RR_PKT_LOCK_EN
                    chk("beat_last", 32'(out_last), 32'(e.last));
`endif
                end
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
            sel_prev   = out_sel;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // One random-phase cycle: retire accepted beats, optionally raise new ones.
    task automatic rnd_cycle(input bit allow_new);
        logic [3:0] acc;
        @(negedge clk);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (acc[k]) in_valid[k] = 1'b0;
            if (allow_new && !in_valid[k] && ($urandom_range(0, 1) == 1)) begin
                in_valid[k]        = 1'b1;
                in_data[k*8 +: 8]  = {2'(k), tx_seq[k]};
                tx_seq[k]          = tx_seq[k] + 6'd1;
                tx_cnt[k]++;
            end
        end
        out_ready = ($urandom_range(0, 3) != 0) || !allow_new;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] seq31[5];
        seq31 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 4; k++) begin
            tx_seq[k] = 6'd0; rx_seq[k] = 6'd0; tx_cnt[k] = 0; rx_cnt[k] = 0;
        end
        rst_n = 1'b0; in_valid = 4'h0; in_data = 32'h0; out_ready = 1'b0;
`ifdef MUX_4X1_RR_PKT_LOCK_EN
        in_last = 4'hF;
`endif
        repeat (2) @(posedge clk);

        // Reset state with all channels already requesting.
        in_valid = 4'hF; in_data = 32'h13121110; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);

        // All valid, out_ready high: 0,1,2,3,0 one per cycle.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ready_is("rr_ready", 4'(4'b0001 << seq31[i]));
            push(seq31[i], 8'h10 + 8'(seq31[i]), 1'b1);
            step();
        end
        in_valid = 4'h0;
        step();
        step();
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // last_grant=0, ch3 and ch0 requesting: ch3 first.
        in_valid = 4'b1001; in_data = 32'h23000020;
        ready_is("rr_wrap_ch3", 4'b1000);
        push(2'd3, 8'h23, 1'b1);
        step();
        ready_is("rr_wrap_ch0", 4'b0001);
        push(2'd0, 8'h20, 1'b1);
        step();
        in_valid = 4'h0;
        step();
        step();

        // Stall: ch2 beat A5 held until out_ready, next beat 5A waits.
        in_valid = 4'b0100; in_data = 32'h00A50000; out_ready = 1'b0;
        ready_is("stall_accept", 4'b0100);
        push(2'd2, 8'hA5, 1'b1);
        step();
        in_data = 32'h005A0000;
        for (int i = 0; i < 3; i++) begin
            ready_is("stall_ready_low", 4'b0000);
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_data", 32'(out_data), 32'hA5);
            chk("stall_hold_sel", 32'(out_sel), 32'd2);
            step();
        end
        out_ready = 1'b1;
        ready_is("stall_release", 4'b0100);
        push(2'd2, 8'h5A, 1'b1);
        step();
        in_valid = 4'h0;
        step();
        step();

        // Reset while a beat is held: beat discarded, ch0 first afterwards.
        in_valid = 4'b0010; in_data = 32'h00007700; out_ready = 1'b0;
        #1;
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 4'h0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        in_valid = 4'b1001; in_data = 32'h34000031; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ready_is("post_rst_ch0", 4'b0001);
        push(2'd0, 8'h31, 1'b1);
        step();
        ready_is("post_rst_ch3", 4'b1000);
        push(2'd3, 8'h34, 1'b1);
        step();
        in_valid = 4'h0;
        step();
        step();

`ifdef MUX_4X1_RR_PKT_LOCK_EN
        // Move last_grant to 0, then ch1 sends a 3-beat packet while ch0, ch2 wait.
        in_valid = 4'b0001; in_data = 32'h00000050; in_last = 4'hF;
        ready_is("lock_prep", 4'b0001);
        push(2'd0, 8'h50, 1'b1);
        step();
        in_valid = 4'b0111; in_data = 32'h00524150; in_last = 4'b0101;
        ready_is("lock_b1", 4'b0010);
        push(2'd1, 8'h41, 1'b0);
        step();
        in_data = 32'h00524250;
        ready_is("lock_b2", 4'b0010);
        push(2'd1, 8'h42, 1'b0);
        step();
        in_data = 32'h00524350; in_last = 4'hF;
        ready_is("lock_b3", 4'b0010);
        push(2'd1, 8'h43, 1'b1);
        step();
        in_valid = 4'b0101;
        ready_is("lock_after", 4'b0100);
        push(2'd2, 8'h52, 1'b1);
        step();
        ready_is("lock_ch0", 4'b0001);
        push(2'd0, 8'h50, 1'b1);
        step();
        in_valid = 4'h0;
        step();
        step();
`endif

        chk("directed_drained", 32'(exp_q.size()), 32'd0);

        // Random valid/ready traffic; each channel holds valid until accepted.
        rnd_mode = 1'b1;
        in_data  = 32'h0;
        for (int c = 0; c < 1000; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 200 && in_valid != 4'h0; c++) rnd_cycle(1'b0);
        chk("rnd_drain", 32'(in_valid), 32'd0);
        out_ready = 1'b1;
        step();
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            chk("rnd_count", 32'(rx_cnt[k]), 32'(tx_cnt[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
